// File: rtl/ma_kernel_sequencer.sv
// ma_kernel_sequencer
// Feeds one external mult_adder. The block accepts one window of MA_TREE_SIZE
// signed bytes and replays it against each of NUM_KERNELS stored kernels on
// consecutive cycles. A tag pipe follows each issue through the mult_adder
// latency so that returning dot products land in an output FIFO together with
// their kernel index and a last-kernel flag. Issue is gated by a credit that
// counts both FIFO occupancy and products still in flight, so the FIFO cannot
// overflow.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     window offered by the producer
//   in_ready     sequencer idle and able to take a window
//   in_window    window, element i at [8i+7:8i]
//   kernel_bank  static kernels, kernel k at slice k
//   ma_in        window presented to the mult_adder
//   ma_kernel    kernel presented to the mult_adder
//   ma_out       dot product returning from the mult_adder
//   out_valid    FIFO head valid
//   out_ready    consumer takes the head
//   out_data     signed dot product at the FIFO head
//   out_kidx     kernel index of out_data
//   out_last     out_data belongs to kernel NUM_KERNELS-1
//   busy         any work pending (running, in flight or buffered)

// Overflow watchdog for the output FIFO, bound into the sequencer.
module ma_kernel_sequencer_chk (
    input logic clock,
    input logic reset,
    input logic fifo_push,
    input logic fifo_full
);
    // Credit accounting must keep every product write within FIFO capacity.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset) !(fifo_push && fifo_full));
endmodule

module ma_kernel_sequencer #(
    parameter int MA_TREE_SIZE = 8,
    parameter int NUM_KERNELS  = 4,
    parameter int MA_LATENCY   = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int KW           = $clog2(NUM_KERNELS)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [8*MA_TREE_SIZE-1:0]          in_window,
    input  logic [NUM_KERNELS*8*MA_TREE_SIZE-1:0] kernel_bank,
    output logic [8*MA_TREE_SIZE-1:0]          ma_in,
    output logic [8*MA_TREE_SIZE-1:0]          ma_kernel,
    input  logic [31:0]                        ma_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [31:0]                        out_data,
    output logic [KW-1:0]                      out_kidx,
    output logic                               out_last,
    output logic                               busy
);
    localparam int VW = 8 * MA_TREE_SIZE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_KERNELS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [KW-1:0]   k_r;
    logic [KW-1:0]   k_next_s;
    logic [VW-1:0]   window_r;
    logic            in_ready_r;
    logic [VW-1:0]   ma_in_r;
    logic [VW-1:0]   ma_kernel_r;
    logic            accept_s;
    logic            issue_s;
    logic            credit_ok_s;
    logic [CW-1:0]   inflight_s;

    // Tag pipe: index 0 is aligned with ma_in, index MA_LATENCY with ma_out.
    logic [MA_LATENCY:0] tag_valid_r;
    logic [MA_LATENCY:0] tag_last_r;
    logic [KW-1:0]       tag_kidx_r [0:MA_LATENCY];

    logic [31:0]     fifo_data_r [0:FIFO_DEPTH-1];
    logic [KW-1:0]   fifo_kidx_r [0:FIFO_DEPTH-1];
    logic            fifo_last_r [0:FIFO_DEPTH-1];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_s;
    logic            pop_s;
    logic            fifo_full_s;

    assign push_s      = tag_valid_r[MA_LATENCY];
    assign out_valid   = (count_r != {CW{1'b0}});
    assign pop_s       = out_valid && out_ready;
    assign fifo_full_s = (count_r == CW'(FIFO_DEPTH));

    assign in_ready  = in_ready_r;
    assign ma_in     = ma_in_r;
    assign ma_kernel = ma_kernel_r;
    assign out_data  = out_valid ? fifo_data_r[rd_ptr_r] : 32'd0;
    assign out_kidx  = out_valid ? fifo_kidx_r[rd_ptr_r] : {KW{1'b0}};
    assign out_last  = out_valid ? fifo_last_r[rd_ptr_r] : 1'b0;
    assign busy      = (state_r != ST_IDLE) || (tag_valid_r != '0) || out_valid;

    // Credit: buffered plus in-flight results must stay below FIFO capacity.
    always_comb begin
        inflight_s = {CW{1'b0}};
        for (int i = 0; i <= MA_LATENCY; i++) begin
            inflight_s = inflight_s + CW'(tag_valid_r[i]);
        end
        credit_ok_s = (({1'b0, count_r} + {1'b0, inflight_s}) < SW'(FIFO_DEPTH));
    end

    // Next-state logic: accept in IDLE, one kernel per credited cycle in RUN.
    always_comb begin
        state_next_s = state_r;
        k_next_s     = k_r;
        accept_s     = 1'b0;
        issue_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_RUN;
                    k_next_s     = {KW{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (credit_ok_s) begin
                    issue_s = 1'b1;
                    if (k_r == K_LAST) begin
                        state_next_s = ST_IDLE;
                        k_next_s     = {KW{1'b0}};
                    end else begin
                        k_next_s = k_r + KW'(1);
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                k_next_s     = {KW{1'b0}};
            end
        endcase
    end

    // Control state, kernel counter, captured window and registered in_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            k_r        <= {KW{1'b0}};
            window_r   <= {VW{1'b0}};
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            k_r        <= k_next_s;
            in_ready_r <= (state_next_s == ST_IDLE);
            if (accept_s) begin
                window_r <= in_window;
            end
        end
    end

    // Operand registers; they hold between issues and the stale product is untagged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ma_in_r     <= {VW{1'b0}};
            ma_kernel_r <= {VW{1'b0}};
        end else if (issue_s) begin
            ma_in_r     <= window_r;
            ma_kernel_r <= kernel_bank[k_r*VW +: VW];
        end
    end

    // Tag pipe shifts every cycle so a tag exits together with its product.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_valid_r <= '0;
            tag_last_r  <= '0;
            for (int i = 0; i <= MA_LATENCY; i++) begin
                tag_kidx_r[i] <= {KW{1'b0}};
            end
        end else begin
            tag_valid_r   <= {tag_valid_r[MA_LATENCY-1:0], issue_s};
            tag_last_r    <= {tag_last_r[MA_LATENCY-1:0], (k_r == K_LAST)};
            tag_kidx_r[0] <= k_r;
            for (int i = 1; i <= MA_LATENCY; i++) begin
                tag_kidx_r[i] <= tag_kidx_r[i-1];
            end
        end
    end

    // Output FIFO: storage, wrapping pointers and occupancy count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_r[i] <= 32'd0;
                fifo_kidx_r[i] <= {KW{1'b0}};
                fifo_last_r[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= ma_out;
                fifo_kidx_r[wr_ptr_r] <= tag_kidx_r[MA_LATENCY];
                fifo_last_r[wr_ptr_r] <= tag_last_r[MA_LATENCY];
                wr_ptr_r              <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    ma_kernel_sequencer_chk u_chk (
        .clock     (clock),
        .reset     (reset),
        .fifo_push (push_s),
        .fifo_full (fifo_full_s)
    );
endmodule

// File: tb/tb_ma_kernel_sequencer.sv
module tb_ma_kernel_sequencer;
    localparam int MTS = 8;
    localparam int NK  = 4;
    localparam int LAT = 4;
    localparam int FD  = 8;
    localparam int KW  = 2;
    localparam int VW  = 8 * MTS;

    logic                clock = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [VW-1:0]       in_window;
    logic [NK*VW-1:0]    kernel_bank;
    logic [VW-1:0]       ma_in;
    logic [VW-1:0]       ma_kernel;
    logic [31:0]         ma_out = 32'd0;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_data;
    logic [KW-1:0]       out_kidx;
    logic                out_last;
    logic                busy;

    typedef struct packed {
        logic [31:0]   data;
        logic [KW-1:0] kidx;
        logic          last;
    } res_t;

    res_t got_q[$];
    int   got_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [VW-1:0] ws [0:2];

    ma_kernel_sequencer #(
        .MA_TREE_SIZE (MTS),
        .NUM_KERNELS  (NK),
        .MA_LATENCY   (LAT),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_window   (in_window),
        .kernel_bank (kernel_bank),
        .ma_in       (ma_in),
        .ma_kernel   (ma_kernel),
        .ma_out      (ma_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_kidx    (out_kidx),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Signed dot product of two byte vectors.
    function automatic logic [31:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
        int s = 0;
        for (int i = 0; i < MTS; i++) begin
            int x = $signed(a[8*i +: 8]);
            int y = $signed(b[8*i +: 8]);
            s += x * y;
        end
        return 32'(s);
    endfunction

    function automatic logic [VW-1:0] kslice(input int k);
        return kernel_bank[k*VW +: VW];
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic res_t expect_res(input logic [VW-1:0] w, input int k);
        res_t r;
        r.data = dot(w, kslice(k));
        r.kidx = KW'(k);
        r.last = (k == NK - 1);
        return r;
    endfunction

    // External mult_adder: four register stages from operands to product.
    logic [31:0] p1 = 32'd0, p2 = 32'd0, p3 = 32'd0;
    always @(posedge clock) begin
        p1     <= dot(ma_in, ma_kernel);
        p2     <= p1;
        p3     <= p2;
        ma_out <= p3;
    end

    // Record every result the consumer takes, with the cycle it was taken.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            got_q.push_back(res_t'{data: out_data, kidx: out_kidx, last: out_last});
            got_cyc.push_back(cyc);
        end
    end

    task automatic send(input logic [VW-1:0] w, output int acc);
        acc = -1;
        in_window = w;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                acc = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL send_accept got timeout required in_ready within 200 cycles");
        end
    endtask

    task automatic wait_results(input int n);
        for (int t = 0; t < 400 && got_q.size() < n; t++) @(posedge clock);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic random_bank();
        for (int k = 0; k < NK; k++) kernel_bank[k*VW +: VW] = rand_vec();
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_window = '0; kernel_bank = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({out_valid, out_last, busy, in_ready} !== 4'b0000 || out_data !== 32'd0 || out_kidx !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%0b last=%0b busy=%0b ready=%0b data=%0h kidx=%0d required all 0",
                     out_valid, out_last, busy, in_ready, out_data, out_kidx);
        end
        checks++;
        if (ma_in !== 64'd0 || ma_kernel !== 64'd0) begin
            errors++;
            $display("FAIL reset_ma got ma_in=%0h ma_kernel=%0h required 0", ma_in, ma_kernel);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got in_ready=%0b busy=%0b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_single();
        logic [VW-1:0] w;
        int acc;
        res_t e;
        for (int k = 0; k < NK; k++)
            for (int i = 0; i < MTS; i++) kernel_bank[k*VW + 8*i +: 8] = 8'(k + 1);
        for (int i = 0; i < MTS; i++) w[8*i +: 8] = 8'd1;
        got_q.delete(); got_cyc.delete(); out_ready = 1'b1;
        send(w, acc);
        wait_results(4);
        checks++;
        if (got_q.size() !== 4) begin
            errors++;
            $display("FAIL single_count got %0d required 4", got_q.size());
        end
        for (int j = 0; j < got_q.size() && j < 4; j++) begin
            e.data = 32'(8 * (j + 1)); e.kidx = KW'(j); e.last = (j == 3);
            checks++;
            if (got_q[j] !== e) begin
                errors++;
                $display("FAIL single_res[%0d] got %0d/%0d/%0b required %0d/%0d/%0b",
                         j, got_q[j].data, got_q[j].kidx, got_q[j].last, e.data, e.kidx, e.last);
            end
            checks++;
            if (got_cyc[j] !== acc + 6 + j) begin
                errors++;
                $display("FAIL single_latency[%0d] got cycle %0d required %0d", j, got_cyc[j], acc + 6 + j);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got busy=%0b required 0", busy);
        end
    endtask

    task automatic test_signed();
        logic [VW-1:0] w;
        int acc;
        res_t e;
        random_bank();
        for (int i = 0; i < MTS; i++) begin
            kernel_bank[8*i +: 8] = 8'h7F;
            w[8*i +: 8] = 8'h80;
        end
        got_q.delete(); got_cyc.delete(); out_ready = 1'b1;
        send(w, acc);
        wait_results(4);
        checks++;
        if (got_q.size() !== 4) begin
            errors++;
            $display("FAIL signed_count got %0d required 4", got_q.size());
        end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0].data !== 32'hFFFE0400 || got_q[0].kidx !== 2'd0) begin
                errors++;
                $display("FAIL signed_min got %0h kidx %0d required fffe0400 kidx 0", got_q[0].data, got_q[0].kidx);
            end
        end
        for (int j = 1; j < got_q.size() && j < 4; j++) begin
            e = expect_res(w, j);
            checks++;
            if (got_q[j] !== e) begin
                errors++;
                $display("FAIL signed_res[%0d] got %0h/%0d required %0h/%0d", j, got_q[j].data, got_q[j].kidx, e.data, e.kidx);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc [0:1];
        int n = 0;
        logic hit;
        res_t e;
        random_bank();
        ws[0] = rand_vec(); ws[1] = rand_vec();
        got_q.delete(); got_cyc.delete(); out_ready = 1'b1;
        acc[0] = 0; acc[1] = -100;
        in_window = ws[0]; in_valid = 1'b1;
        for (int t = 0; t < 100 && n < 2; t++) begin
            @(negedge clock);
            hit = in_ready;
            @(posedge clock);
            #1;
            if (hit) begin
                acc[n] = cyc;
                n++;
                if (n < 2) in_window = ws[n];
            end
        end
        in_valid = 1'b0;
        checks++;
        if (acc[1] - acc[0] !== 5) begin
            errors++;
            $display("FAIL b2b_accept_spacing got %0d required 5", acc[1] - acc[0]);
        end
        wait_results(8);
        checks++;
        if (got_q.size() !== 8) begin
            errors++;
            $display("FAIL b2b_count got %0d required 8", got_q.size());
        end
        for (int j = 0; j < got_q.size() && j < 8; j++) begin
            e = expect_res(ws[j / 4], j % 4);
            checks++;
            if (got_q[j] !== e) begin
                errors++;
                $display("FAIL b2b_res[%0d] got %0h/%0d/%0b required %0h/%0d/%0b",
                         j, got_q[j].data, got_q[j].kidx, got_q[j].last, e.data, e.kidx, e.last);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        res_t e;
        random_bank();
        for (int i = 0; i < 3; i++) ws[i] = rand_vec();
        got_q.delete(); got_cyc.delete(); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(ws[i], acc);
        repeat (20) @(posedge clock);
        #1;
        checks++;
        if (got_q.size() !== 0 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got taken=%0d valid=%0b ready=%0b busy=%0b required 0 1 0 1",
                     got_q.size(), out_valid, in_ready, busy);
        end
        checks++;
        if (ma_kernel !== kslice(3) || ma_in !== ws[1]) begin
            errors++;
            $display("FAIL bp_issue_count got ma_kernel=%0h ma_in=%0h required %0h %0h", ma_kernel, ma_in, kslice(3), ws[1]);
        end
        out_ready = 1'b1;
        wait_results(12);
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (got_q.size() !== 12 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got count=%0d busy=%0b required 12 0", got_q.size(), busy);
        end
        for (int j = 0; j < got_q.size() && j < 12; j++) begin
            e = expect_res(ws[j / 4], j % 4);
            checks++;
            if (got_q[j] !== e) begin
                errors++;
                $display("FAIL bp_res[%0d] got %0h/%0d/%0b required %0h/%0d/%0b",
                         j, got_q[j].data, got_q[j].kidx, got_q[j].last, e.data, e.kidx, e.last);
            end
        end
    endtask

    task automatic test_toggle();
        int a, b;
        res_t e;
        random_bank();
        ws[0] = rand_vec(); ws[1] = rand_vec();
        got_q.delete(); got_cyc.delete(); out_ready = 1'b0;
        fork
            begin
                send(ws[0], a);
                send(ws[1], b);
            end
            begin
                for (int t = 0; t < 300 && got_q.size() < 8; t++) begin
                    @(posedge clock);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (got_q.size() !== 8) begin
            errors++;
            $display("FAIL toggle_count got %0d required 8", got_q.size());
        end
        for (int j = 0; j < got_q.size() && j < 8; j++) begin
            e = expect_res(ws[j / 4], j % 4);
            checks++;
            if (got_q[j] !== e) begin
                errors++;
                $display("FAIL toggle_res[%0d] got %0h/%0d required %0h/%0d", j, got_q[j].data, got_q[j].kidx, e.data, e.kidx);
            end
        end
    endtask

    task automatic test_reset_mid();
        int a, b;
        res_t e;
        random_bank();
        for (int i = 0; i < 3; i++) ws[i] = rand_vec();
        got_q.delete(); got_cyc.delete(); out_ready = 1'b0;
        send(ws[0], a);
        send(ws[1], b);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got valid=%0b busy=%0b required 1 1", out_valid, busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'd0 || ma_in !== 64'd0 || ma_kernel !== 64'd0) begin
            errors++;
            $display("FAIL midrst_clear got valid=%0b busy=%0b data=%0h ma_in=%0h required 0 0 0 0",
                     out_valid, busy, out_data, ma_in);
        end
        got_q.delete(); got_cyc.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL midrst_stale got %0d results required 0", got_q.size());
        end
        send(ws[2], a);
        wait_results(4);
        checks++;
        if (got_q.size() !== 4) begin
            errors++;
            $display("FAIL midrst_count got %0d required 4", got_q.size());
        end
        for (int j = 0; j < got_q.size() && j < 4; j++) begin
            e = expect_res(ws[2], j);
            checks++;
            if (got_q[j] !== e) begin
                errors++;
                $display("FAIL midrst_res[%0d] got %0h/%0d required %0h/%0d", j, got_q[j].data, got_q[j].kidx, e.data, e.kidx);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_toggle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
